// File: rtl/hub75_pkg.sv
// Shared types and helpers for the HUB75 scan engine.
// The state order follows one column shift, then blank, latch and show.
package hub75_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CAPTURE,
        CLK_LO,
        CLK_HI,
        BLANK,
        LATCH,
        SHOW
    } state_t;

    // BCM on-time of bit-plane p: each plane is lit twice as long as the one below it.
    function automatic int plane_time(input int oe_base, input int p);
        return oe_base << p;
    endfunction

endpackage

// File: rtl/hub75_shift_clk.sv
// Panel shift-clock phase timer: counts CLK_DIV cycles in each of the low
// and high phases and flags the last cycle of the current phase.
module hub75_shift_clk #(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clk_lo_i,
    input  logic clk_hi_i,
    output logic display_clk_o,
    output logic phase_done_o
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             active;

    assign active        = clk_lo_i | clk_hi_i;
    assign phase_done_o  = active && (cnt_q == DIV_W'(CLK_DIV - 1));
    assign display_clk_o = clk_hi_i;

    // The counter restarts at every phase boundary so both phases get CLK_DIV cycles.
    always_comb begin
        cnt_d = cnt_q;
        if (!active || phase_done_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/hub75_scanner.sv
// HUB75 scan engine: fetches one bit-plane per row from a double-buffered
// framebuffer, shifts it into the panel and shows it for a BCM-weighted time.
module hub75_scanner #(
    parameter int COLS      = 64,
    parameter int SCAN_ROWS = 32,
    parameter int CHANNELS  = 4,
    parameter int BPP       = 4,
    parameter int CLK_DIV   = 1,
    parameter int OE_BASE   = 8,
    parameter int BLANK     = 2,
    localparam int COL_W    = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int ROW_W    = (SCAN_ROWS > 1) ? $clog2(SCAN_ROWS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    output logic                    fb_rd_en,
    output logic                    fb_buf,
    input  logic [CHANNELS*BPP-1:0] fb_data_a,
    input  logic [CHANNELS*BPP-1:0] fb_data_b,
    input  logic                    swap_req,
    output logic                    swap_ack,
    output logic                    frame_start,
    output logic [ROW_W-1:0]        row_addr,
    output logic [COL_W-1:0]        col_addr,
    output logic                    display_oe,
    output logic                    latch,
    output logic                    display_clk,
    output logic [CHANNELS-1:0]     dout_a,
    output logic [CHANNELS-1:0]     dout_b
);

    import hub75_pkg::*;

    localparam int PL_W   = (BPP > 1) ? $clog2(BPP) : 1;
    localparam int SHOW_W = $clog2(OE_BASE << (BPP - 1)) + 1;
    localparam int BLK_W  = $clog2(BLANK) + 1;
    localparam int CNT_W  = (SHOW_W > BLK_W) ? SHOW_W : BLK_W;

    state_t              state_q, state_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [PL_W-1:0]     plane_q, plane_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ROW_W-1:0]    row_addr_q, row_addr_d;
    logic                fb_buf_q, fb_buf_d;
    logic                swap_ack_q, swap_ack_d;
    logic [CHANNELS-1:0] dout_a_q, dout_a_d;
    logic [CHANNELS-1:0] dout_b_q, dout_b_d;
    logic                phase_done;
    logic                last_col, last_row, last_plane, show_done;

    hub75_shift_clk #(
        .CLK_DIV(CLK_DIV)
    ) u_shift_clk (
        .clk          (clk),
        .rst          (rst),
        .clk_lo_i     (state_q == CLK_LO),
        .clk_hi_i     (state_q == CLK_HI),
        .display_clk_o(display_clk),
        .phase_done_o (phase_done)
    );

    assign last_col   = (col_q == COL_W'(COLS - 1));
    assign last_row   = (row_q == ROW_W'(SCAN_ROWS - 1));
    assign last_plane = (plane_q == PL_W'(BPP - 1));
    assign show_done  = (cnt_q == CNT_W'(plane_time(OE_BASE, int'(plane_q)) - 1));

    // Sequencer; row_addr is loaded on entry to blanking so it never moves while lit.
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        plane_d    = plane_q;
        cnt_d      = cnt_q;
        row_addr_d = row_addr_q;
        fb_buf_d   = fb_buf_q;
        swap_ack_d = 1'b0;
        dout_a_d   = dout_a_q;
        dout_b_d   = dout_b_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (enable) state_d = FETCH;
            end
            FETCH: state_d = CAPTURE;
            CAPTURE: begin
                for (int c = 0; c < CHANNELS; c++) begin
                    dout_a_d[c] = fb_data_a[c*BPP + int'(plane_q)];
                    dout_b_d[c] = fb_data_b[c*BPP + int'(plane_q)];
                end
                state_d = CLK_LO;
            end
            CLK_LO: if (phase_done) state_d = CLK_HI;
            CLK_HI: begin
                if (phase_done) begin
                    if (last_col) begin
                        col_d      = '0;
                        cnt_d      = '0;
                        row_addr_d = row_q;
                        state_d    = hub75_pkg::BLANK;
                    end else begin
                        col_d   = col_q + COL_W'(1);
                        state_d = FETCH;
                    end
                end
            end
            hub75_pkg::BLANK: begin
                if (cnt_q == CNT_W'(BLANK - 1)) begin
                    cnt_d   = '0;
                    state_d = LATCH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            LATCH: begin
                cnt_d   = '0;
                state_d = SHOW;
            end
            SHOW: begin
                if (show_done) begin
                    cnt_d = '0;
                    if (last_plane) begin
                        plane_d = '0;
                        if (last_row) begin
                            row_d = '0;
                            if (swap_req) begin
                                fb_buf_d   = ~fb_buf_q;
                                swap_ack_d = 1'b1;
                            end
                        end else begin
                            row_d = row_q + ROW_W'(1);
                        end
                    end else begin
                        plane_d = plane_q + PL_W'(1);
                    end
                    if (enable) begin
                        state_d = FETCH;
                    end else begin
                        row_d   = '0;
                        plane_d = '0;
                        col_d   = '0;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            col_q      <= '0;
            row_q      <= '0;
            plane_q    <= '0;
            cnt_q      <= '0;
            row_addr_q <= '0;
            fb_buf_q   <= 1'b0;
            swap_ack_q <= 1'b0;
            dout_a_q   <= '0;
            dout_b_q   <= '0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            plane_q    <= plane_d;
            cnt_q      <= cnt_d;
            row_addr_q <= row_addr_d;
            fb_buf_q   <= fb_buf_d;
            swap_ack_q <= swap_ack_d;
            dout_a_q   <= dout_a_d;
            dout_b_q   <= dout_b_d;
        end
    end

    assign fb_rd_en    = (state_q == FETCH);
    assign frame_start = (state_q == FETCH) && (row_q == '0) && (plane_q == '0) && (col_q == '0);
    assign display_oe  = (state_q != SHOW);
    assign latch       = (state_q == LATCH);
    assign fb_buf      = fb_buf_q;
    assign swap_ack    = swap_ack_q;
    assign row_addr    = row_addr_q;
    assign col_addr    = col_q;
    assign dout_a      = dout_a_q;
    assign dout_b      = dout_b_q;

endmodule

// File: tb/tb_hub75_scanner.sv
// Self-checking bench for hub75_scanner: random framebuffer contents and swap
// requests, compared every cycle against a slot/offset timeline model.
module tb_hub75_scanner;

    localparam int COLS  = 4;
    localparam int SR    = 2;
    localparam int CH    = 4;
    localparam int BPP   = 2;
    localparam int D     = 1;
    localparam int OE    = 2;
    localparam int BL    = 1;
    localparam int CPC   = 2 + 2*D;
    localparam int FRAME = SR * (BPP*(COLS*CPC + BL + 1) + OE*((1 << BPP) - 1));

    localparam int K_FETCH = 0, K_CAP = 1, K_LO = 2, K_HI = 3, K_BLK = 4, K_LAT = 5, K_SHW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          swap_req = 1'b0;
    logic [7:0]    fb_data_a = '0;
    logic [7:0]    fb_data_b = '0;
    logic          fb_rd_en, fb_buf, swap_ack, frame_start;
    logic          row_addr;
    logic [1:0]    col_addr;
    logic          display_oe, latch, display_clk;
    logic [CH-1:0] dout_a, dout_b;

    hub75_scanner #(
        .COLS(COLS), .SCAN_ROWS(SR), .CHANNELS(CH), .BPP(BPP),
        .CLK_DIV(D), .OE_BASE(OE), .BLANK(BL)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .fb_rd_en(fb_rd_en), .fb_buf(fb_buf),
        .fb_data_a(fb_data_a), .fb_data_b(fb_data_b),
        .swap_req(swap_req), .swap_ack(swap_ack), .frame_start(frame_start),
        .row_addr(row_addr), .col_addr(col_addr),
        .display_oe(display_oe), .latch(latch), .display_clk(display_clk),
        .dout_a(dout_a), .dout_b(dout_b)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] memA [2][SR][COLS];
    logic [7:0] memB [2][SR][COLS];
    int curRow = 0;

    // Framebuffer: data appears one cycle after the read strobe.
    always @(posedge clk) begin
        if (fb_rd_en) begin
            fb_data_a <= memA[fb_buf][curRow][col_addr];
            fb_data_b <= memB[fb_buf][curRow][col_addr];
        end
    end

    int   eKind, eRow, ePlane, eCol, eOff, eTf, eFrame;
    int   tg = 0;
    int   expRowAddr = 0;
    logic expBuf = 1'b0;
    logic expAck = 1'b0;
    logic pendSwap = 1'b0;

    function automatic int slotLen(input int p);
        return COLS*CPC + BL + 1 + (OE << p);
    endfunction

    function automatic logic [CH-1:0] planeBits(input logic [7:0] d, input int p);
        logic [CH-1:0] r;
        for (int c = 0; c < CH; c++) r[c] = d[c*BPP + p];
        return r;
    endfunction

    // Locate cycle t of a run within frame / (row, plane) slot / phase.
    task automatic expectAt(input int t);
        int o, k, ph;
        eFrame = t / FRAME;
        eTf    = t % FRAME;
        o = eTf;
        k = 0;
        while (o >= slotLen(k % BPP)) begin
            o -= slotLen(k % BPP);
            k++;
        end
        eRow   = k / BPP;
        ePlane = k % BPP;
        eCol   = 0;
        eOff   = 0;
        if (o < COLS*CPC) begin
            eCol = o / CPC;
            ph   = o % CPC;
            if (ph == 0)          eKind = K_FETCH;
            else if (ph == 1)     eKind = K_CAP;
            else if (ph < 2 + D)  eKind = K_LO;
            else                  eKind = K_HI;
        end else begin
            eOff = o - COLS*CPC;
            if (eOff < BL)        eKind = K_BLK;
            else if (eOff == BL)  eKind = K_LAT;
            else                  eKind = K_SHW;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h (t=%0d)", tag, obs, exp, tg);
        end
    endtask

    task automatic applyStimulus(input logic rstV, input logic enV, input logic swV);
        rst      = rstV;
        enable   = enV;
        swap_req = swV;
        @(posedge clk);
        #1;
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_rd_en"},  fb_rd_en,    0);
        checkOutput({tag, "_buf"},    fb_buf,      0);
        checkOutput({tag, "_ack"},    swap_ack,    0);
        checkOutput({tag, "_fstart"}, frame_start, 0);
        checkOutput({tag, "_row"},    row_addr,    0);
        checkOutput({tag, "_col"},    col_addr,    0);
        checkOutput({tag, "_oe"},     display_oe,  1);
        checkOutput({tag, "_latch"},  latch,       0);
        checkOutput({tag, "_dclk"},   display_clk, 0);
        checkOutput({tag, "_douta"},  dout_a,      0);
        checkOutput({tag, "_doutb"},  dout_b,      0);
    endtask

    task automatic runUntil(input int tEnd, input int dropAt, input int rstAt);
        logic en, sw;
        while (tg < tEnd) begin
            expectAt(tg);
            curRow = eRow;
            en = (dropAt >= 0 && tg >= dropAt) ? 1'b0 : 1'b1;
            if (eFrame == 0)      sw = 1'b1;
            else if (eFrame == 1) sw = 1'b0;
            else                  sw = 1'($urandom_range(0, 1));
            if (tg > 0 && eTf == 0) begin
                if (pendSwap) expBuf = ~expBuf;
                expAck   = pendSwap;
                pendSwap = 1'b0;
            end else begin
                expAck = 1'b0;
            end
            if (eKind == K_BLK && eOff == 0) expRowAddr = eRow;

            checkOutput("rd_en", fb_rd_en, eKind == K_FETCH);
            checkOutput("frame_start", frame_start,
                        eKind == K_FETCH && eRow == 0 && ePlane == 0 && eCol == 0);
            if (eKind == K_FETCH) checkOutput("col_addr", col_addr, eCol);
            checkOutput("display_clk", display_clk, eKind == K_HI);
            checkOutput("latch", latch, eKind == K_LAT);
            checkOutput("display_oe", display_oe, eKind != K_SHW);
            checkOutput("row_addr", row_addr, expRowAddr);
            checkOutput("fb_buf", fb_buf, expBuf);
            checkOutput("swap_ack", swap_ack, expAck);
            if (eKind == K_LO || eKind == K_HI) begin
                checkOutput("dout_a", dout_a, planeBits(memA[expBuf][eRow][eCol], ePlane));
                checkOutput("dout_b", dout_b, planeBits(memB[expBuf][eRow][eCol], ePlane));
            end

            if (eTf == FRAME - 1) pendSwap = sw;
            applyStimulus(tg == rstAt, en, sw);
            tg++;
        end
    endtask

    initial begin
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < SR; r++)
                for (int c = 0; c < COLS; c++) begin
                    memA[b][r][c] = 8'($urandom);
                    memB[b][r][c] = 8'($urandom);
                end
        memA[0][0][0] = 8'hA5;
        memB[0][1][2] = 8'h5A;

        $display("[TB] reset phase");
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0);
        checkReset("reset");
        repeat (2) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            checkOutput("idle_rd_en", fb_rd_en, 0);
            checkOutput("idle_oe", display_oe, 1);
        end

        $display("[TB] three frames with swap held, cleared, then random");
        applyStimulus(1'b0, 1'b1, 1'b0);
        tg = 0;
        runUntil(3*FRAME + 42, 3*FRAME + 39, -1);

        $display("[TB] enable dropped during show");
        repeat (5) begin
            checkOutput("stop_rd_en", fb_rd_en, 0);
            checkOutput("stop_oe", display_oe, 1);
            checkOutput("stop_latch", latch, 0);
            checkOutput("stop_dclk", display_clk, 0);
            checkOutput("stop_ack", swap_ack, 0);
            checkOutput("stop_buf", fb_buf, expBuf);
            applyStimulus(1'b0, 1'b0, 1'b0);
        end

        $display("[TB] restart then reset during CLK_HI");
        applyStimulus(1'b0, 1'b1, 1'b0);
        tg = 0;
        pendSwap = 1'b0;
        runUntil(4, -1, 3);
        checkReset("midrst");
        repeat (2) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            checkOutput("midrst_latch", latch, 0);
            checkOutput("midrst_oe", display_oe, 1);
        end
        applyStimulus(1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
